// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and sizes for the two-master memory arbiter
package mem_arb_pkg;
  localparam int FUNCT3_W = 3;
  localparam int N_MASTERS = 2;
  typedef enum logic {OWN_M0, OWN_M1} owner_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-input round-robin / fixed-priority grant, optional ownership lock (MEM_ARB_LOCK_EN)
module rr_arb2
  import mem_arb_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_MASTERS-1:0] req,
`ifdef MEM_ARB_LOCK_EN
  input  logic [N_MASTERS-1:0] lock,
`endif
  output logic [N_MASTERS-1:0] gnt
);
  owner_t rr_last;
  logic [N_MASTERS-1:0] elig;
`ifdef MEM_ARB_LOCK_EN
  logic locked;
  owner_t lock_own;
  logic hold;
  assign hold = locked && lock[lock_own];
  assign elig = hold ? req & ((lock_own == OWN_M1) ? 2'b10 : 2'b01) : req;
  // a granted master raising lock keeps ownership until its lock drops
  always_ff @(posedge clk)
    if (!rst_n) begin
      locked   <= 1'b0;
      lock_own <= OWN_M0;
    end else if (!hold) begin
      locked   <= |(gnt & lock);
      lock_own <= gnt[1] ? OWN_M1 : OWN_M0;
    end
`else
  assign elig = req;
`endif
  // grant is suppressed during reset so every output reads 0
  always_comb
    gnt = !rst_n ? 2'b00 :
          (&elig) ? ((FIXED_PRIO || rr_last == OWN_M1) ? 2'b01 : 2'b10) : elig;
  // remember the last winner; M0 wins the first tie after reset
  always_ff @(posedge clk)
    if (!rst_n) rr_last <= OWN_M1;
    else if (|gnt) rr_last <= gnt[1] ? OWN_M1 : OWN_M0;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one sync-read memory port between M0 and M1 (lock ports with MEM_ARB_LOCK_EN)
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                m0_req,
  input  logic                m0_we,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [FUNCT3_W-1:0] m0_func3,
  output logic                m0_gnt,
  output logic                m0_rvalid,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_req,
  input  logic                m1_we,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [FUNCT3_W-1:0] m1_func3,
  output logic                m1_gnt,
  output logic                m1_rvalid,
  output logic [DATA_W-1:0]   m1_rdata,
`ifdef MEM_ARB_LOCK_EN
  input  logic                m0_lock,
  input  logic                m1_lock,
`endif
  output logic                mem_wen,
  output logic [ADDR_W-1:0]   mem_ra,
  output logic [ADDR_W-1:0]   mem_wa,
  output logic [DATA_W-1:0]   mem_wd,
  output logic [FUNCT3_W-1:0] mem_func3,
  input  logic [DATA_W-1:0]   mem_rd
);
  logic [N_MASTERS-1:0] gnt;
  logic rd_pend;
  owner_t rd_owner;
  rr_arb2 #(.FIXED_PRIO(FIXED_PRIO)) u_arb (
    .clk  (clk),
    .rst_n(rst_n),
    .req  ({m1_req, m0_req}),
`ifdef MEM_ARB_LOCK_EN
    .lock ({m1_lock, m0_lock}),
`endif
    .gnt  (gnt)
  );
  assign m0_gnt = gnt[0];
  assign m1_gnt = gnt[1];
  // steer the winner's transaction onto the memory port, zeros when idle
  always_comb begin
    mem_wen   = gnt[0] ? m0_we    : gnt[1] ? m1_we    : 1'b0;
    mem_ra    = gnt[0] ? m0_addr  : gnt[1] ? m1_addr  : '0;
    mem_wd    = gnt[0] ? m0_wdata : gnt[1] ? m1_wdata : '0;
    mem_func3 = gnt[0] ? m0_func3 : gnt[1] ? m1_func3 : '0;
    mem_wa    = mem_ra;
  end
  // track the owner of the read whose data arrives next cycle
  always_ff @(posedge clk)
    if (!rst_n) begin
      rd_pend  <= 1'b0;
      rd_owner <= OWN_M0;
    end else begin
      rd_pend <= |gnt && !mem_wen;
      if (|gnt && !mem_wen) rd_owner <= gnt[1] ? OWN_M1 : OWN_M0;
    end
  // return read data only to its owner; reset kills a pending return
  always_comb begin
    m0_rvalid = rst_n && rd_pend && rd_owner == OWN_M0;
    m1_rvalid = rst_n && rd_pend && rd_owner == OWN_M1;
    m0_rdata  = m0_rvalid ? mem_rd : '0;
    m1_rdata  = m1_rvalid ? mem_rd : '0;
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized scoreboard bench for mem_arbiter (round-robin DUT plus fixed-priority twin)
module tb_mem_arbiter;
  logic clk = 0, rst_n = 0;
  logic m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0, mem_rd = 0;
  logic [2:0] m0_func3 = 0, m1_func3 = 0;
  wire m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, mem_wen;
  wire [31:0] m0_rdata, m1_rdata, mem_ra, mem_wa, mem_wd;
  wire [2:0] mem_func3;
  wire f0_gnt, f0_rvalid, f1_gnt, f1_rvalid, f_wen;
  wire [31:0] f0_rdata, f1_rdata, f_ra, f_wa, f_wd;
  wire [2:0] f_func3;
  int total = 0, passed = 0;

  typedef struct {
    logic [1:0] g, gf, rv;
    logic wen;
    logic [31:0] a, d, rd;
    logic [2:0] f;
  } exp_t;
  exp_t q[$];

  int last = 1, pown = 0, mg = -1;
  bit pend = 0;
  logic [31:0] paddr = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.FIXED_PRIO(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_func3(m0_func3),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_func3(m1_func3),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
`ifdef MEM_ARB_LOCK_EN
    .m0_lock(1'b0), .m1_lock(1'b0),
`endif
    .mem_wen(mem_wen), .mem_ra(mem_ra), .mem_wa(mem_wa), .mem_wd(mem_wd),
    .mem_func3(mem_func3), .mem_rd(mem_rd)
  );

  mem_arbiter #(.FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_func3(m0_func3),
    .m0_gnt(f0_gnt), .m0_rvalid(f0_rvalid), .m0_rdata(f0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_func3(m1_func3),
    .m1_gnt(f1_gnt), .m1_rvalid(f1_rvalid), .m1_rdata(f1_rdata),
`ifdef MEM_ARB_LOCK_EN
    .m0_lock(1'b0), .m1_lock(1'b0),
`endif
    .mem_wen(f_wen), .mem_ra(f_ra), .mem_wa(f_wa), .mem_wd(f_wd),
    .mem_func3(f_func3), .mem_rd(mem_rd)
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEADBEEF : {a[15:0], ~a[31:16]};
  endfunction

  always @(posedge clk) mem_rd <= memf(mem_ra);

  function automatic void chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("gnt", {30'd0, m1_gnt, m0_gnt}, {30'd0, e.g});
      chk("fixed_gnt", {30'd0, f1_gnt, f0_gnt}, {30'd0, e.gf});
      chk("mem_wen", {31'd0, mem_wen}, {31'd0, e.wen});
      chk("mem_ra", mem_ra, e.a);
      chk("mem_wa", mem_wa, e.a);
      chk("mem_wd", mem_wd, e.d);
      chk("mem_func3", {29'd0, mem_func3}, {29'd0, e.f});
      chk("rvalid", {30'd0, m1_rvalid, m0_rvalid}, {30'd0, e.rv});
      chk("m0_rdata", m0_rdata, e.rv[0] ? e.rd : 32'd0);
      chk("m1_rdata", m1_rdata, e.rv[1] ? e.rd : 32'd0);
    end
  end

  task automatic step(input bit rn,
                      input bit r0, input bit w0, input logic [31:0] a0, input logic [31:0] d0, input logic [2:0] f0,
                      input bit r1, input bit w1, input logic [31:0] a1, input logic [31:0] d1, input logic [2:0] f1);
    exp_t e;
    int g;
    rst_n = rn;
    m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0; m0_func3 = f0;
    m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1; m1_func3 = f1;
    e = '{g: 2'b00, gf: 2'b00, rv: 2'b00, wen: 1'b0, a: 32'd0, d: 32'd0, rd: 32'd0, f: 3'd0};
    g = -1;
    if (rn) begin
      if (r0 && r1) g = (last == 1) ? 0 : 1;
      else if (r0) g = 0;
      else if (r1) g = 1;
      e.gf = r0 ? 2'b01 : r1 ? 2'b10 : 2'b00;
      if (pend) begin
        e.rv = (pown == 0) ? 2'b01 : 2'b10;
        e.rd = memf(paddr);
      end
      pend = 0;
      if (g >= 0) begin
        e.g = (g == 0) ? 2'b01 : 2'b10;
        e.wen = (g == 0) ? w0 : w1;
        e.a = (g == 0) ? a0 : a1;
        e.d = (g == 0) ? d0 : d1;
        e.f = (g == 0) ? f0 : f1;
        last = g;
        pend = !e.wen;
        pown = g;
        paddr = e.a;
      end
    end else begin
      last = 1;
      pend = 0;
    end
    mg = g;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit rn);
    step(rn, 0, 0, 32'd0, 32'd0, 3'd0, 0, 0, 32'd0, 32'd0, 3'd0);
  endtask

  initial begin
    bit h0, h1, r0, r1, w0, w1, rn;
    logic [31:0] a0, a1, d0, d1;
    logic [2:0] f0, f1;
    @(posedge clk);
    #1;
    idle(0);
    idle(0);
    step(1, 1, 0, 32'h10, 32'd0, 3'd2, 0, 0, 32'd0, 32'd0, 3'd0);
    idle(1);
    idle(0);
    for (int i = 0; i < 6; i++) step(1, 1, 0, 32'h100, 32'd0, 3'd2, 1, 0, 32'h200, 32'd0, 3'd4);
    idle(1);
    step(1, 0, 0, 32'd0, 32'd0, 3'd0, 1, 1, 32'h8000_0010, 32'h0000_00FF, 3'd2);
    idle(1);
    step(1, 1, 0, 32'h44, 32'd0, 3'd2, 0, 0, 32'd0, 32'd0, 3'd0);
    idle(0);
    step(1, 1, 0, 32'h48, 32'd0, 3'd2, 1, 0, 32'h4C, 32'd0, 3'd2);
    idle(1);
    h0 = 0; h1 = 0;
    r0 = 0; r1 = 0; w0 = 0; w1 = 0;
    a0 = 0; a1 = 0; d0 = 0; d1 = 0; f0 = 0; f1 = 0;
    for (int i = 0; i < 400; i++) begin
      if (!h0) begin
        r0 = $urandom_range(0, 3) != 0; w0 = $urandom_range(0, 1) == 1;
        a0 = $urandom & 32'h0000_FFFC; d0 = $urandom; f0 = 3'($urandom_range(0, 7));
      end
      if (!h1) begin
        r1 = $urandom_range(0, 3) != 0; w1 = $urandom_range(0, 1) == 1;
        a1 = $urandom & 32'h0000_FFFC; d1 = $urandom; f1 = 3'($urandom_range(0, 7));
      end
      rn = $urandom_range(0, 59) != 0;
      step(rn, r0, w0, a0, d0, f0, r1, w1, a1, d1, f1);
      h0 = r0 && mg != 0;
      h1 = r1 && mg != 1;
    end
    idle(1);
    @(negedge clk);
    #1;
    chk("drain", q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
